// File: rtl/wb_spi_arbiter.sv
// wb_spi_arbiter: round-robin Wishbone classic arbiter sharing the single
// wb_spi slave between NUM_M masters. Grant is held for the whole cyc of the
// owner; a watchdog aborts an owner whose strobe goes unacknowledged.
module wb_spi_arbiter #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_M*32-1:0] m_adr_i,
  input  logic [NUM_M*32-1:0] m_dat_i,
  input  logic [NUM_M-1:0]   m_we_i,
  input  logic [NUM_M-1:0]   m_stb_i,
  input  logic [NUM_M-1:0]   m_cyc_i,
  output logic [31:0]        m_dat_o,
  output logic [NUM_M-1:0]   m_ack_o,
  output logic [NUM_M-1:0]   m_err_o,
  output logic [NUM_M-1:0]   gnt_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  output logic               s_we_o,
  output logic               s_stb_o,
  output logic               s_cyc_o,
  input  logic [31:0]        s_dat_i,
  input  logic               s_ack_i
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_ptr;
  logic [NUM_M-1:0] r_gnt;
  logic [NUM_M-1:0] r_err;
  logic [WW-1:0]   r_wdog;

  logic            w_any;
  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_idx;
  logic [GW-1:0]   w_sel;
  logic [GW-1:0]   w_g_next;
  logic            w_own;
  logic            w_cyc_g;
  logic            w_stall;
  logic            w_wd_hit;

  // Round-robin pick: scan offsets high to low so the lowest offset from
  // r_ptr is the last to overwrite, i.e. the winner.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      w_idx = GW'((int'(r_ptr) + i) % NUM_M);
      if (m_cyc_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_own    = (r_state == OWN);
  assign w_cyc_g  = m_cyc_i[r_g];
  assign w_sel    = w_own ? r_g : r_ptr;
  assign w_g_next = (r_g == GW'(NUM_M - 1)) ? '0 : r_g + 1'b1;

  // Address/data path follows the owner; outside OWN it idles on r_ptr's master.
  always_comb begin
    s_adr_o = m_adr_i[31:0];
    s_dat_o = m_dat_i[31:0];
    for (int k = 0; k < NUM_M; k++) begin
      if (w_sel == GW'(k)) begin
        s_adr_o = m_adr_i[k*32 +: 32];
        s_dat_o = m_dat_i[k*32 +: 32];
      end
    end
  end

  assign s_cyc_o  = w_own & m_cyc_i[r_g];
  assign s_stb_o  = w_own & m_stb_i[r_g];
  assign s_we_o   = w_own & m_we_i[r_g];
  assign m_dat_o  = s_dat_i;
  // r_gnt is one-hot of r_g, so masking routes ack to the owner only.
  assign m_ack_o  = r_gnt & {NUM_M{w_own & s_ack_i}};
  assign m_err_o  = r_err;
  assign gnt_o    = r_gnt;

  assign w_stall  = s_stb_o & ~s_ack_i;
  assign w_wd_hit = WD_EN && w_stall && (r_wdog == WD_LAST);

  // Arbitration FSM with watchdog and registered grant/error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_err   <= '0;
      r_wdog  <= '0;
    end else begin
      r_err <= '0;
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_any) begin
            r_state <= OWN;
            r_g     <= w_win;
            r_gnt   <= NUM_M'(1) << w_win;
          end
        end
        OWN: begin
          if (!w_cyc_g) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= w_g_next;
            r_wdog  <= '0;
          end else if (w_wd_hit) begin
            r_state <= ABORT;
            r_err   <= r_gnt;
            r_wdog  <= '0;
          end else if (w_stall && WD_EN) begin
            r_wdog  <= r_wdog + 1'b1;
          end else if (!w_stall) begin
            r_wdog  <= '0;
          end
        end
        ABORT: begin
          r_wdog <= '0;
          if (!w_cyc_g) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= w_g_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Bench for wb_spi_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave, all checked every cycle against a
// transaction-level model of ownership.
module tb_wb_spi_arbiter;
  localparam int NM = 2;
  localparam int TO = 8;
  localparam int IW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NM*32-1:0]  m_adr_i, m_dat_i;
  logic [NM-1:0]     m_we_i, m_stb_i, m_cyc_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
  logic [31:0]       s_adr_o, s_dat_o, s_dat_i;
  logic              s_we_o, s_stb_o, s_cyc_o, s_ack_i;

  wb_spi_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: who owns the slave, and is it aborted
  int md_owner = -1;
  int md_ptr = 0;
  int md_stall = 0;
  bit md_abort = 0;
  bit md_errp = 0;
  bit md_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (md_valid) begin
        logic [NM-1:0] eg, ea, ee;
        logic ec, es, ew;
        eg = '0; ea = '0; ee = '0; ec = 0; es = 0; ew = 0;
        if (md_owner >= 0) begin
          eg = NM'(1) << md_owner;
          if (md_errp) ee = eg;
          if (!md_abort) begin
            ec = m_cyc_i[IW'(md_owner)];
            es = m_stb_i[IW'(md_owner)];
            ew = m_we_i[IW'(md_owner)];
            if (s_ack_i) ea = eg;
          end
        end
        chk("gnt", 32'(gnt_o), 32'(eg));
        chk("ack", 32'(m_ack_o), 32'(ea));
        chk("err", 32'(m_err_o), 32'(ee));
        chk("s_cyc", 32'(s_cyc_o), 32'(ec));
        chk("s_stb", 32'(s_stb_o), 32'(es));
        chk("s_we", 32'(s_we_o), 32'(ew));
        chk("m_dat", m_dat_o, s_dat_i);
        if (md_owner >= 0 && !md_abort) begin
          chk("s_adr", s_adr_o, m_adr_i[md_owner*32 +: 32]);
          chk("s_dat", s_dat_o, m_dat_i[md_owner*32 +: 32]);
        end
      end
      @(posedge clk);
      if (rst) begin
        md_owner = -1; md_abort = 0; md_ptr = 0; md_stall = 0; md_errp = 0;
        md_valid = 1;
      end else begin
        md_errp = 0;
        if (md_owner < 0) begin
          for (int i = 0; i < NM; i++) begin
            int c;
            c = (md_ptr + i) % NM;
            if (md_owner < 0 && m_cyc_i[IW'(c)]) md_owner = c;
          end
        end else if (!m_cyc_i[IW'(md_owner)]) begin
          md_ptr = (md_owner + 1) % NM;
          md_owner = -1; md_abort = 0; md_stall = 0;
        end else if (!md_abort) begin
          if (m_stb_i[IW'(md_owner)] && !s_ack_i) begin
            md_stall++;
            if (TO > 0 && md_stall >= TO) begin
              md_abort = 1; md_errp = 1; md_stall = 0;
            end
          end else md_stall = 0;
        end
      end
    end
  end

  // ---------------- stimulus agents
  int rem[NM];
  bit rnd_mode = 0, persist = 0, rst_req = 0, clr_req = 0;
  int ack_mode = 0, ack_pct = 50, req_pct = 30;
  logic [NM-1:0] lat_ack, lat_err;

  task automatic new_beat(input int k);
    m_stb_i[IW'(k)] = 1'b1;
    if (rnd_mode) begin
      m_adr_i[k*32 +: 32] = $urandom;
      m_dat_i[k*32 +: 32] = $urandom;
      m_we_i[IW'(k)] = 1'($urandom_range(0, 1));
    end else begin
      m_adr_i[k*32 +: 32] = 32'h0000_8000;
      m_dat_i[k*32 +: 32] = 32'h0000_00A5;
      m_we_i[IW'(k)] = 1'b1;
    end
  endtask

  task automatic drop(input int k);
    rem[k] = 0;
    m_cyc_i[IW'(k)] = 1'b0;
    m_stb_i[IW'(k)] = 1'b0;
  endtask

  // One clock: latch this cycle's responses, then drive the next cycle.
  task automatic cycle();
    @(negedge clk);
    lat_ack = m_ack_o;
    lat_err = m_err_o;
    @(posedge clk);
    #1;
    rst = rst_req;
    for (int k = 0; k < NM; k++) begin
      if (clr_req) drop(k);
      else if (m_cyc_i[IW'(k)]) begin
        if (lat_err[IW'(k)]) drop(k);
        else if (lat_ack[IW'(k)] && m_stb_i[IW'(k)]) begin
          rem[k]--;
          if (rem[k] <= 0) drop(k);
          else new_beat(k);
        end else if (rnd_mode && $urandom_range(0, 99) < 2) drop(k);
        else if (rnd_mode) m_stb_i[IW'(k)] = ($urandom_range(0, 9) != 0);
      end else begin
        if (rem[k] <= 0 && (persist || (rnd_mode && $urandom_range(0, 99) < req_pct)))
          rem[k] = rnd_mode ? $urandom_range(1, 4) : 1;
        if (rem[k] > 0) begin
          m_cyc_i[IW'(k)] = 1'b1;
          new_beat(k);
        end
      end
    end
    #1;
    case (ack_mode)
      0: s_ack_i = 1'b0;
      1: s_ack_i = s_stb_o;
      2: s_ack_i = ($urandom_range(0, 99) < ack_pct);
      default: s_ack_i = 1'b1;
    endcase
    s_dat_i = $urandom;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int owners[$];
    int gaps[$];
    int idle_run, stb_at, err_at, first_own, a0, a1_in0, a1;
    logic [NM-1:0] prev;
    bit seen1;
    for (int k = 0; k < NM; k++) rem[k] = 0;
    rst = 1; m_adr_i = '0; m_dat_i = '0; m_we_i = '0; m_stb_i = '0; m_cyc_i = '0;
    s_dat_i = '0; s_ack_i = 0;
    rst_req = 1;
    repeat (3) cycle();
    rst_req = 0;
    cycle();
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_scyc", 32'(s_cyc_o), 0);
    chk("rst_ack", 32'(m_ack_o), 0);
    chk("rst_err", 32'(m_err_o), 0);

    // Single write from master 0
    ack_mode = 1; rem[0] = 1;
    cycle();
    chk("w_pre_gnt", 32'(gnt_o), 0);
    cycle();
    chk("w_gnt", 32'(gnt_o), 32'h1);
    chk("w_sdat", s_dat_o, 32'h0000_00A5);
    chk("w_swe", 32'(s_we_o), 1);
    chk("w_ack", 32'(m_ack_o), 32'h1);
    cycle();
    cycle();
    chk("w_release", 32'(gnt_o), 0);

    // Stray slave ack while idle
    ack_mode = 3;
    cycle();
    chk("stray_ack", 32'(m_ack_o), 0);
    chk("stray_gnt", 32'(gnt_o), 0);
    ack_mode = 0;
    cycle();
    chk("stray_after", 32'(gnt_o), 0);

    // Continuous requests from both masters: alternate with one idle cycle
    rst_req = 1; cycle(); rst_req = 0; cycle();
    ack_mode = 1; persist = 1; idle_run = 0; prev = '0;
    for (int n = 0; n < 60 && owners.size() < 4; n++) begin
      cycle();
      if (gnt_o != 0) begin
        if (prev == 0) begin
          owners.push_back(gnt_o[1] ? 1 : 0);
          gaps.push_back(idle_run);
        end
        idle_run = 0;
      end else idle_run++;
      prev = gnt_o;
    end
    persist = 0;
    chk("alt_count", 32'(owners.size()), 4);
    for (int i = 0; i < owners.size(); i++) begin
      chk("alt_order", 32'(owners[i]), 32'(i % 2));
      if (i > 0) chk("alt_gap", 32'(gaps[i]), 1);
    end
    repeat (8) cycle();

    // Watchdog: slave never acks
    ack_mode = 0; rem[0] = 1; stb_at = -1; err_at = -1;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (s_stb_o && stb_at < 0) stb_at = n;
      if (err_at >= 0 && n == err_at + 1) chk("to_err_pulse", 32'(m_err_o), 0);
      if (m_err_o != 0 && err_at < 0) begin
        err_at = n;
        chk("to_err", 32'(m_err_o), 32'h1);
        chk("to_scyc", 32'(s_cyc_o), 0);
        chk("to_gnt_hold", 32'(gnt_o), 32'h1);
      end
      if (err_at >= 0 && n > err_at + 3) break;
    end
    chk("to_latency", 32'(err_at - stb_at), 8);
    chk("to_idle", 32'(gnt_o), 0);
    ack_mode = 1; rem[1] = 1;
    cycle(); cycle();
    chk("to_regrant", 32'(gnt_o), 32'h2);
    repeat (4) cycle();

    // Reset while master 1 owns mid-beat
    rem[0] = 1;
    repeat (5) cycle();
    ack_mode = 0; rem[1] = 1;
    cycle(); cycle();
    chk("rm_own1", 32'(gnt_o), 32'h2);
    chk("rm_stb", 32'(s_stb_o), 1);
    rst_req = 1; cycle();
    rst_req = 0; clr_req = 1; cycle(); clr_req = 0;
    chk("rm_gnt", 32'(gnt_o), 0);
    chk("rm_scyc", 32'(s_cyc_o), 0);

    // Simultaneous 3-beat requests after reset: master 0 first, uninterrupted
    ack_mode = 1; rem[0] = 3; rem[1] = 3;
    first_own = -1; a0 = 0; a1_in0 = 0; a1 = 0; seen1 = 0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (gnt_o != 0 && first_own < 0) first_own = gnt_o[1] ? 1 : 0;
      if (gnt_o == 2'b01) begin
        if (m_ack_o[0]) a0++;
        if (m_ack_o[1]) a1_in0++;
      end
      if (gnt_o == 2'b10) begin
        seen1 = 1;
        if (m_ack_o[1]) a1++;
      end
      if (seen1 && gnt_o == 0) break;
    end
    chk("mb_first", 32'(first_own), 0);
    chk("mb_ack0", 32'(a0), 3);
    chk("mb_ack1_in0", 32'(a1_in0), 0);
    chk("mb_ack1", 32'(a1), 3);

    // Randomized traffic, including stray acks, stalls and resets
    rnd_mode = 1; ack_mode = 2;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin ack_pct = 60; req_pct = 30; end
        1: begin ack_pct = 0;  req_pct = 50; end
        2: begin ack_pct = 25; req_pct = 80; end
        default: begin ack_pct = 90; req_pct = 15; end
      endcase
      for (int n = 0; n < 600; n++) begin
        rst_req = ($urandom_range(0, 399) == 0);
        cycle();
      end
    end
    rst_req = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_spi_arbiter.md
# wb_spi_arbiter

Round-robin Wishbone arbiter that shares the single `wb_spi` slave (mapped at 0x0000_8000) between up to four Wishbone classic masters, such as the CPU data port and a DMA/boot loader. It grants the SPI slave to one master per bus cycle, holds the grant for the whole `cyc` assertion so multi-beat SPI sequences are not interleaved, and routes `ack` to the owner only. A per-cycle watchdog terminates hung transactions with an error.

## Interface
- `NUM_M`, 2: number of masters, legal values 2..4.
- `TIMEOUT`, 64: cycles of `s_stb_o` without `s_ack_i` before the error abort; 0 disables the watchdog.
- `clk`  in  1  system clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m_adr_i`  in  NUM_M*32  master addresses; master k occupies bits [32k+31:32k].
- `m_dat_i`  in  NUM_M*32  master write data, packed the same way.
- `m_we_i`  in  NUM_M  per-master write enable.
- `m_stb_i`  in  NUM_M  per-master strobe.
- `m_cyc_i`  in  NUM_M  per-master cycle; this is the request.
- `m_dat_o`  out  32  read data; `s_dat_i` broadcast to all masters.
- `m_ack_o`  out  NUM_M  per-master acknowledge.
- `m_err_o`  out  NUM_M  per-master watchdog error.
- `gnt_o`  out  NUM_M  one-hot current owner; all zero when idle.
- `s_adr_o`, `s_dat_o`  out  32 each  to `wb_spi` `wb_adr_i` / `wb_dat_i`.
- `s_we_o`, `s_stb_o`, `s_cyc_o`  out  1 each  to `wb_spi`.
- `s_dat_i`  in  32  from `wb_spi` `wb_dat_o`.
- `s_ack_i`  in  1  from `wb_spi` `wb_ack_o`.

## Operation
- States:
  - IDLE: no owner.
  - OWN: master g owns the slave.
  - ABORT: master g is waiting out a watchdog abort.
- IDLE to OWN:
  - Condition: any `m_cyc_i` is high at the clock edge.
  - Winner: the first requester searching from `ptr`, wrapping (`ptr`, `ptr`+1, … mod NUM_M).
  - Effect: `g` and `gnt_o` are registered.
- OWN behaviour:
  - `s_adr_o`, `s_dat_o`, `s_we_o`, `s_stb_o` and `s_cyc_o` are combinational muxes of master g's inputs.
  - `m_ack_o[g] = s_ack_i`; all other `m_ack_o` bits are 0.
  - Non-owners' `m_stb_i` are ignored; their `ack` stays low.
- OWN to IDLE:
  - Condition: `m_cyc_i[g]` is low at the edge.
  - Effect: `gnt_o` clears and `ptr` becomes (g+1) mod NUM_M.
- OWN to ABORT (watchdog):
  - `wdog` counts edges with `s_stb_o`=1 and `s_ack_i`=0.
  - It clears on `s_ack_i`, on `s_stb_o`=0, and on leaving OWN.
  - When `wdog` reaches TIMEOUT-1 with `stb` still high and no `ack`, the FSM enters ABORT.
  - `m_err_o[g]` pulses high for exactly the first ABORT cycle.
- ABORT behaviour:
  - `s_cyc_o`, `s_stb_o` and `s_we_o` are forced 0.
  - `m_ack_o` is all 0; `gnt_o` keeps g.
- ABORT to IDLE:
  - Condition: `m_cyc_i[g]` is low.
  - Effect: `ptr` advances as on a normal release.
- Outside OWN, `s_cyc_o`, `s_stb_o` and `s_we_o` are 0. `s_adr_o` and `s_dat_o` are muxed from `ptr`'s master; their value does not matter.
- Widths: `wdog` is $clog2(TIMEOUT+1) bits and never wraps.

## Timing
- Reset values:
  - State: IDLE.
  - `ptr`: 0, so master 0 has first priority.
  - `gnt_o`, `m_ack_o`, `m_err_o`, `s_cyc_o`, `s_stb_o`, `s_we_o`: all 0.
  - `wdog`: 0.
- Grant latency: a request raised before edge N is granted at edge N. Slave signals follow from cycle N+1, with no added latency to `ack`.
- Release:
  - At least one IDLE cycle separates consecutive owners.
  - Back-to-back requesters see a 2-cycle handover: release edge, then arbitration edge.
- Simultaneous requests: `ptr` decides.
  - With NUM_M=2, alternating strict requests from both masters are granted 0,1,0,1.
- A master that drops and re-raises `cyc` in the same cycle as a release edge is treated as a new request. It loses priority to others via `ptr`.
- `s_ack_i` in IDLE or ABORT is discarded and not forwarded.
- `rst` mid-transaction: everything returns to reset values at that edge. No `ack` or `err` is issued for the cut transaction.
- TIMEOUT=0: ABORT is unreachable and `m_err_o` stays 0.

## Test plan
- Single master 0 writes 0xA5 to 0x8000:
  - `gnt_o`=01 one edge after `cyc`.
  - `s_dat_o`=0x000000A5 and `s_we_o`=1.
  - `m_ack_o`=01 when the slave acks.
  - `gnt_o`=00 after `cyc` drops.
- Masters 0 and 1 raise `cyc` in the same cycle, each doing 3 back-to-back writes:
  - Master 0 is served first with all 3 beats uninterrupted.
  - Master 1 is then served; `m_ack_o[1]` is never 1 during master 0's ownership.
- Both masters request continuously for 4 bus cycles:
  - Grant order is 0,1,0,1.
  - Exactly one idle cycle between owners.
- Slave never acks with TIMEOUT=8:
  - `m_err_o[g]` is high for one cycle, 8 cycles after `stb`.
  - `s_cyc_o` drops to 0.
  - State returns to IDLE after the master drops `cyc`; the next request is granted normally.
- `rst` asserted while master 1 owns mid-beat:
  - Next cycle: `gnt_o`=0, `s_cyc_o`=0, `ptr`=0.
  - A subsequent simultaneous request grants master 0.
- Stray `s_ack_i` pulse while idle:
  - All `m_ack_o` remain 0.
  - State is unchanged.
